// File: rtl/bcd_to_binary_seq.sv
// Sequential 3-digit BCD (000..399) to binary converter using reverse double-dabble.
// One shift/correct iteration per clock; start/busy/done handshake with overflow and digit-error flags.
module bcd_to_binary_seq #(
  parameter bit SATURATE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       ovf,
  output logic       err,
  output logic [1:0] state_dbg
);

  // Handshake: start is sampled only in IDLE and never queued; busy is high on
  // every iteration cycle; done is a one-cycle pulse and result/ovf/err are
  // valid in that cycle and hold until the next done pulse.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [18:0] w;
  logic [18:0] w_nx;
  logic [18:0] w_sr;
  logic [18:0] w_iter;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nx;
  logic [7:0]  result_nx;
  logic        ovf_nx;
  logic        err_nx;
  logic        digits_ok;

  function automatic logic [3:0] adj3(input logic [3:0] d);
    adj3 = (d >= 4'd8) ? d - 4'd3 : d;
  endfunction

  // Working register: hundreds [18:17], tens [16:13], ones [12:9], binary [8:0].
  // Bits flow down through the fixed digit fields; the 2-bit hundreds field can
  // never reach 8 so it needs no correction.
  assign w_sr      = {1'b0, w[18:1]};
  assign w_iter    = {w_sr[18:17], adj3(w_sr[16:13]), adj3(w_sr[12:9]), w_sr[8:0]};
  assign digits_ok = (tens <= 4'd9) && (ones <= 4'd9);

  assign busy      = (state == CONV);
  assign done      = (state == DONE);
  assign state_dbg = state;

  always_comb begin
    state_nx  = state;
    w_nx      = w;
    cnt_nx    = cnt;
    result_nx = result;
    ovf_nx    = ovf;
    err_nx    = err;
    case (state)
      IDLE: begin
        if (start) begin
          w_nx   = {hundreds, tens, ones, 9'b0};
          cnt_nx = 4'd0;
          if (!digits_ok) begin
            state_nx  = DONE;
            result_nx = 8'h00;
            ovf_nx    = 1'b0;
            err_nx    = 1'b1;
          end else begin
            state_nx = CONV;
          end
        end
      end
      CONV: begin
        w_nx   = w_iter;
        cnt_nx = cnt + 4'd1;
        if (cnt == 4'd8) begin
          // Final iteration: the binary value is already in the low 9 bits.
          state_nx  = DONE;
          ovf_nx    = w_iter[8];
          err_nx    = 1'b0;
          result_nx = (w_iter[8] && SATURATE) ? 8'hFF : w_iter[7:0];
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      w      <= '0;
      cnt    <= 4'd0;
      result <= 8'h00;
      ovf    <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_nx;
      w      <= w_nx;
      cnt    <= cnt_nx;
      result <= result_nx;
      ovf    <= ovf_nx;
      err    <= err_nx;
    end
  end

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Bench for bcd_to_binary_seq: saturating and wrapping instances driven in parallel,
// a cycle-level arithmetic model compared every cycle, plus literal expectations.
module tb_bcd_to_binary_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;

  logic       busy1, done1, ovf1, err1;
  logic [7:0] result1;
  logic [1:0] state1;
  logic       busy0, done0, ovf0, err0;
  logic [7:0] result0;
  logic [1:0] state0;

  int vectors     = 0;
  int miscompares = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  bcd_to_binary_seq dut_sat (
    .clk(clk), .rst(rst), .start(start),
    .hundreds(hundreds), .tens(tens), .ones(ones),
    .busy(busy1), .done(done1), .result(result1),
    .ovf(ovf1), .err(err1), .state_dbg(state1)
  );

  bcd_to_binary_seq #(.SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .start(start),
    .hundreds(hundreds), .tens(tens), .ones(ones),
    .busy(busy0), .done(done0), .result(result0),
    .ovf(ovf0), .err(err0), .state_dbg(state0)
  );

  // ---------------- behavioural model ----------------
  // cyc numbers the clock cycles; a transaction is described by the cycles in
  // which busy and done must be high, and by the values held from done onward.
  int         cyc        = 0;
  int         m_done_cyc = -1;
  int         m_busy_lo  = 1;
  int         m_busy_hi  = 0;
  logic [7:0] p_res1 = 8'h00, p_res0 = 8'h00, h_res1 = 8'h00, h_res0 = 8'h00;
  logic       p_ovf = 1'b0, p_err = 1'b0, h_ovf = 1'b0, h_err = 1'b0;

  always @(posedge clk) begin
    int c;
    int v;
    c = cyc;
    if (rst) begin
      m_done_cyc = c;
      m_busy_lo  = 1;
      m_busy_hi  = 0;
      h_res1 = 8'h00; h_res0 = 8'h00; h_ovf = 1'b0; h_err = 1'b0;
    end else if (start && c > m_done_cyc) begin
      v = 100 * int'(hundreds) + 10 * int'(tens) + int'(ones);
      if (tens > 4'd9 || ones > 4'd9) begin
        p_res1 = 8'h00; p_res0 = 8'h00; p_ovf = 1'b0; p_err = 1'b1;
        m_busy_lo  = 1;
        m_busy_hi  = 0;
        m_done_cyc = c + 1;
      end else begin
        p_ovf  = (v > 255);
        p_res0 = v[7:0];
        p_res1 = p_ovf ? 8'hFF : v[7:0];
        p_err  = 1'b0;
        m_busy_lo  = c + 1;
        m_busy_hi  = c + 9;
        m_done_cyc = c + 10;
      end
    end
    cyc = c + 1;
    if (!rst && cyc == m_done_cyc) begin
      h_res1 = p_res1; h_res0 = p_res0; h_ovf = p_ovf; h_err = p_err;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic exp_busy;
    logic exp_done;
    if (cyc >= 1) begin
      exp_busy = (cyc >= m_busy_lo) && (cyc <= m_busy_hi);
      exp_done = (cyc == m_done_cyc);
      check("sat busy",   busy1,   exp_busy);
      check("sat done",   done1,   exp_done);
      check("sat result", result1, h_res1);
      check("sat ovf",    ovf1,    h_ovf);
      check("sat err",    err1,    h_err);
      check("wrap busy",   busy0,   exp_busy);
      check("wrap done",   done0,   exp_done);
      check("wrap result", result0, h_res0);
      check("wrap ovf",    ovf0,    h_ovf);
      check("wrap err",    err0,    h_err);
    end
  end

  // ---------------- driver tasks ----------------
  int start_cyc = 0;

  task automatic pulse_start(input logic [1:0] h, input logic [3:0] t, input logic [3:0] o);
    @(negedge clk);
    hundreds  = h;
    tens      = t;
    ones      = o;
    start     = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start    = 1'b0;
    hundreds = 2'($urandom_range(0, 3));
    tens     = 4'($urandom_range(0, 15));
    ones     = 4'($urandom_range(0, 15));
  endtask

  task automatic wait_done(input string name, input logic [7:0] r1, input logic [7:0] r0,
                           input logic ov, input logic er, input int lat);
    int n;
    n = 0;
    while (!done1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!done1) begin
      vectors++;
      miscompares++;
      $display("FAIL %s timeout: done not seen within 20 cycles", name);
    end else begin
      check({name, " latency"}, 16'(cyc - start_cyc), 16'(lat));
      check({name, " result sat"},  result1, r1);
      check({name, " result wrap"}, result0, r0);
      check({name, " ovf"}, ovf1, ov);
      check({name, " err"}, err1, er);
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int ndone;
    int v;
    logic [7:0] r1;
    rst      = 1'b1;
    start    = 1'b0;
    hundreds = 2'd0;
    tens     = 4'd0;
    ones     = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset result", result1, 8'h00);
    check("reset busy", busy1, 1'b0);
    check("reset done", done1, 1'b0);
    check("reset flags", {ovf1, err1}, 2'b00);

    pulse_start(2'd2, 4'd5, 4'd5);
    wait_done("255", 8'hFF, 8'hFF, 1'b0, 1'b0, 10);

    pulse_start(2'd1, 4'd2, 4'd3);
    wait_done("123", 8'h7B, 8'h7B, 1'b0, 1'b0, 10);
    repeat (5) @(negedge clk);
    check("123 hold", result1, 8'h7B);
    pulse_start(2'd0, 4'd0, 4'd7);
    wait_done("007", 8'h07, 8'h07, 1'b0, 1'b0, 10);

    pulse_start(2'd2, 4'd5, 4'd6);
    wait_done("256", 8'hFF, 8'h00, 1'b1, 1'b0, 10);
    pulse_start(2'd3, 4'd9, 4'd9);
    wait_done("399", 8'hFF, 8'h8F, 1'b1, 1'b0, 10);

    pulse_start(2'd1, 4'hA, 4'd0);
    wait_done("tens A", 8'h00, 8'h00, 1'b0, 1'b1, 1);
    pulse_start(2'd0, 4'd3, 4'hF);
    wait_done("ones F", 8'h00, 8'h00, 1'b0, 1'b1, 1);
    pulse_start(2'd0, 4'd0, 4'd0);
    wait_done("000", 8'h00, 8'h00, 1'b0, 1'b0, 10);

    // start held high: accepted every 11 cycles, never in the done cycle
    @(negedge clk);
    hundreds = 2'd0; tens = 4'd4; ones = 4'd2;
    start = 1'b1;
    ndone = 0;
    for (int i = 0; i < 33; i++) begin
      @(negedge clk);
      if (done1) ndone++;
    end
    start = 1'b0;
    check("held start done count", 16'(ndone), 16'd3);
    check("held start result", result1, 8'h2A);
    repeat (12) @(negedge clk);

    // reset in C5 abandons the conversion
    pulse_start(2'd1, 4'd2, 4'd3);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", busy1, 1'b0);
    check("abort result", result1, 8'h00);
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done1) ndone++;
    end
    check("abort no done", 16'(ndone), 16'd0);
    pulse_start(2'd0, 4'd9, 4'd9);
    wait_done("099", 8'h63, 8'h63, 1'b0, 1'b0, 10);

    // full valid range
    for (int h = 0; h < 4; h++) begin
      for (int t = 0; t < 10; t++) begin
        for (int o = 0; o < 10; o++) begin
          v  = 100 * h + 10 * t + o;
          r1 = (v > 255) ? 8'hFF : v[7:0];
          pulse_start(2'(h), 4'(t), 4'(o));
          wait_done("sweep", r1, v[7:0], v > 255, 1'b0, 10);
        end
      end
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

endmodule
